// File: rtl/window_gen_3x3.sv
// Turns a raster pixel stream into interior 3x3 neighbourhood windows.
// Two line buffers feed a 3-column shift window; there is a single output register.
module window_gen_3x3 #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   axis_i_data,
  input  logic               axis_i_vld,
  output logic               axis_i_rdy,
  output logic [9*PIX_W-1:0] axis_o_data,
  output logic               axis_o_vld,
  input  logic               axis_o_rdy,
  output logic               frame_done
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);

  logic [PIX_W-1:0]   lb0_q [IMG_W];
  logic [PIX_W-1:0]   lb1_q [IMG_W];
  logic [PIX_W-1:0]   win_q [3][3];
  logic [PIX_W-1:0]   win_d [3][3];
  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic               vld_q, vld_d;
  logic [9*PIX_W-1:0] data_q, data_d;
  logic               fd_q, fd_d;
  logic [9*PIX_W-1:0] win_packed;
  logic               acc, col_last, row_last, emit;

  assign axis_i_rdy  = ~vld_q | axis_o_rdy;
  assign acc         = axis_i_vld & axis_i_rdy;
  assign col_last    = (col_q == ColLast);
  assign row_last    = (row_q == RowLast);
  // Only interior positions produce a window; stale columns at c=0,1 are never emitted.
  assign emit        = acc && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign axis_o_vld  = vld_q;
  assign axis_o_data = data_q;
  assign frame_done  = fd_q;

  always_comb begin
    win_d = win_q;
    if (acc) begin
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = lb1_q[col_q];
      win_d[1][2] = lb0_q[col_q];
      win_d[2][2] = axis_i_data;
    end
  end

  always_comb begin
    win_packed = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        win_packed[(3*i+j)*PIX_W +: PIX_W] = win_d[i][j];
      end
    end
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    vld_d  = vld_q;
    data_d = data_q;
    fd_d   = acc && col_last && row_last;
    if (acc) begin
      col_d = col_last ? '0 : col_q + 1'b1;
      if (col_last) begin
        row_d = row_last ? '0 : row_q + 1'b1;
      end
      vld_d = emit;
      if (emit) begin
        data_d = win_packed;
      end
    end else if (axis_o_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q  <= '0;
      row_q  <= '0;
      vld_q  <= 1'b0;
      data_q <= '0;
      fd_q   <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      vld_q  <= vld_d;
      data_q <= data_d;
      fd_q   <= fd_d;
    end
  end

  // Storage needs no reset: row/col gating keeps stale contents from ever being emitted.
  always_ff @(posedge clk) begin
    if (acc) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= axis_i_data;
    end
    win_q <= win_d;
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Scoreboard bench for window_gen_3x3 on a 4x3 image: directed frames, backpressure,
// input gaps, back-to-back frames and a mid-frame reset.
module tb_window_gen_3x3;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned IMG_W = 4;
  localparam int unsigned IMG_H = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [PIX_W-1:0]   axis_i_data = '0;
  logic               axis_i_vld = 1'b0;
  logic               axis_i_rdy;
  logic [9*PIX_W-1:0] axis_o_data;
  logic               axis_o_vld;
  logic               axis_o_rdy = 1'b1;
  logic               frame_done;

  int tests = 0;
  int fails = 0;
  int fd_cnt = 0;
  int bp_mode = 0;
  bit gaps = 1'b0;
  logic [71:0] exp_q[$];
  bit          stall_prev = 1'b0;
  logic [71:0] stall_data = '0;

  window_gen_3x3 #(
    .PIX_W(PIX_W),
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .axis_i_data(axis_i_data),
    .axis_i_vld (axis_i_vld),
    .axis_i_rdy (axis_i_rdy),
    .axis_o_data(axis_o_data),
    .axis_o_vld (axis_o_vld),
    .axis_o_rdy (axis_o_rdy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Window k of a frame, hand-computed for a 4-wide image: w00..w22 = base + k + {0,1,2,4,5,6,8,9,10}.
  function automatic logic [71:0] mk_win(int base, int k);
    int v [9];
    logic [71:0] w;
    v = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    w = '0;
    for (int n = 0; n < 9; n++) w[n*8 +: 8] = 8'(v[n] + base + k);
    return w;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      if (stall_prev) begin
        check("stall_vld", 72'(axis_o_vld), 72'(1));
        check("stall_data", axis_o_data, stall_data);
      end
      if (axis_o_vld && !axis_o_rdy) check("in_rdy_low", 72'(axis_i_rdy), 72'(0));
      if (axis_o_vld && axis_o_rdy) begin
        if (exp_q.size() == 0) check("spurious_vld", 72'(axis_o_vld), 72'(0));
        else check("window", axis_o_data, exp_q.pop_front());
      end
      if (frame_done) fd_cnt++;
      stall_prev = axis_o_vld && !axis_o_rdy;
      stall_data = axis_o_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      axis_o_rdy = (bp_mode == 1) ? ~axis_o_rdy : 1'b1;
    end
  end

  task automatic do_reset();
    axis_i_vld = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", 72'(axis_o_vld), 72'(0));
    check("rst_data", axis_o_data, 72'(0));
    check("rst_fd", 72'(frame_done), 72'(0));
    rst = 1'b1;
  endtask

  task automatic send_px(input int p);
    bit a;
    int n;
    if (gaps) begin
      while ($urandom_range(0, 9) < 3) begin
        axis_i_vld = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    axis_i_vld  = 1'b1;
    axis_i_data = 8'(p);
    n = 0;
    forever begin
      @(negedge clk);
      a = axis_i_rdy;
      @(posedge clk);
      #1;
      if (a) break;
      n++;
      if (n > 50) begin
        tests++;
        fails++;
        $display("FAIL accept_timeout: pixel %0d not accepted within 50 cycles", p);
        break;
      end
    end
    axis_i_vld = 1'b0;
  endtask

  task automatic run_frame(input int base);
    exp_q.push_back(mk_win(base, 0));
    exp_q.push_back(mk_win(base, 1));
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        send_px(base + 4 * r + c);
        if (r == 2 && c >= 2) begin
          check("latency_vld", 72'(axis_o_vld), 72'(1));
          check("latency_data", axis_o_data, mk_win(base, c - 2));
        end
        if (r == 2 && c == 3) check("frame_done_pulse", 72'(frame_done), 72'(1));
      end
    end
  endtask

  task automatic drain(input int exp_fd);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (6) @(posedge clk);
    #1;
    check("drain_empty", 72'(exp_q.size()), 72'(0));
    check("fd_count", 72'(fd_cnt), 72'(exp_fd));
    exp_q.delete();
    fd_cnt = 0;
  endtask

  initial begin
    do_reset();
    check("rst_in_rdy", 72'(axis_i_rdy), 72'(1));

    // Plain stream
    run_frame(0);
    drain(1);

    // Output backpressure toggling every cycle
    bp_mode = 1;
    run_frame(0);
    drain(1);
    bp_mode = 0;

    // Input gaps
    gaps = 1'b1;
    run_frame(0);
    drain(1);
    gaps = 1'b0;

    // Two frames back to back
    do_reset();
    run_frame(0);
    run_frame(100);
    drain(2);

    // Abort a frame after 7 pixels, then a clean frame
    for (int n = 0; n < 7; n++) send_px(200 + n);
    do_reset();
    run_frame(0);
    drain(1);

    // Backpressure combined with gaps over two frames
    bp_mode = 1;
    gaps = 1'b1;
    run_frame(20);
    run_frame(40);
    drain(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
